// File: rtl/reaction_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_fsm_pkg
// Description : Shared types and defaults for the reaction-time tester:
//               state enumeration, timing/count defaults, LFSR seed,
//               BCD display geometry and a binary-to-BCD helper used to
//               turn the decimal count limit into a BCD compare constant.
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_fsm_pkg;

  localparam int unsigned c_min_delay_ms = 1000;
  localparam int unsigned c_max_count    = 9999;
  localparam logic [15:0] c_lfsr_seed    = 16'hACE1;

  localparam int unsigned c_bcd_digit_w  = 4;
  localparam int unsigned c_bcd_digits   = 4;
  localparam int unsigned c_bcd_w        = c_bcd_digits * c_bcd_digit_w;
  localparam int unsigned c_delay_w      = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_DONE    = 3'd3,
    ST_EARLY   = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  // Elaboration-time conversion of a decimal value to packed BCD digits.
  function automatic logic [c_bcd_w-1:0] bin_to_bcd4(input int unsigned value);
    logic [c_bcd_w-1:0] result;
    int unsigned        rem;
    result = '0;
    rem    = value;
    for (int i = 0; i < int'(c_bcd_digits); i++) begin
      result[i*c_bcd_digit_w +: c_bcd_digit_w] = c_bcd_digit_w'(rem % 10);
      rem = rem / 10;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter4
// Description : Four-digit BCD up-counter with synchronous clear, count
//               enable and saturation at MAX_BCD (never wraps).
// Ports       : clk    - system clock
//               rst    - asynchronous active-low reset
//               clr    - synchronous clear to 0000 (wins over en)
//               en     - advance by one when not saturated
//               q      - packed BCD count, [15:12] thousands .. [3:0] units
//               at_max - count currently equals MAX_BCD
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter4
  import reaction_fsm_pkg::*;
#(
  parameter logic [c_bcd_w-1:0] MAX_BCD = 16'h9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [c_bcd_w-1:0] q,
  output logic               at_max
);

  logic [c_bcd_w-1:0]      r_q;
  logic [c_bcd_w-1:0]      w_inc;
  // w_carry_in[i] is set when the +1 ripples into digit i.
  logic [c_bcd_digits-1:0] w_carry_in;

  assign w_carry_in[0] = 1'b1;

  for (genvar i = 0; i < int'(c_bcd_digits); i++) begin : g_digit
    logic [c_bcd_digit_w-1:0] w_d;
    logic                     w_nine;

    assign w_d    = r_q[i*c_bcd_digit_w +: c_bcd_digit_w];
    assign w_nine = (w_d == c_bcd_digit_w'(9));
    assign w_inc[i*c_bcd_digit_w +: c_bcd_digit_w] =
        !w_carry_in[i] ? w_d :
        (w_nine ? '0 : w_d + c_bcd_digit_w'(1));

    if (i < int'(c_bcd_digits) - 1) begin : g_carry
      assign w_carry_in[i+1] = w_carry_in[i] & w_nine;
    end
  end

  assign at_max = (r_q == MAX_BCD);
  assign q      = r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && !at_max) begin
      r_q <= w_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reaction_fsm.sv
`default_nettype none
// ============================================================================
// Module      : reaction_fsm
// Description : Reaction-time tester. A start press begins a random wait
//               (MIN_DELAY_MS + 0..2047 ms); the LED then lights and the
//               reaction time is counted in BCD milliseconds until the
//               react press, an early press, or the count limit.
// Ports       : clk       - system clock (100 MHz)
//               rst       - asynchronous active-low reset
//               ms_tick   - one-clk strobe every millisecond
//               btn_start - debounced start button (asynchronous)
//               btn_react - debounced reaction button (asynchronous)
//               go_led    - high while waiting for the reaction
//               bcd       - reaction time, four BCD digits
//               done      - reaction captured
//               too_soon  - pressed before the LED lit
//               timeout   - count limit reached without a press
//               delay_ms  - random wait length of the current trial
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_fsm
  import reaction_fsm_pkg::*;
#(
  parameter int unsigned MIN_DELAY_MS = c_min_delay_ms,
  parameter int unsigned MAX_COUNT    = c_max_count,
  parameter logic [15:0] LFSR_SEED    = c_lfsr_seed
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ms_tick,
  input  logic                 btn_start,
  input  logic                 btn_react,
  output logic                 go_led,
  output logic [c_bcd_w-1:0]   bcd,
  output logic                 done,
  output logic                 too_soon,
  output logic                 timeout,
  output logic [c_delay_w-1:0] delay_ms
);

  localparam logic [c_bcd_w-1:0] c_max_bcd = bin_to_bcd4(MAX_COUNT);

  // --------------------------------------------------------------------------
  // Button synchronizers and rising-edge detectors.
  // r_fill counts the first two clocks after reset so the synchronizer
  // contents are known to be real samples; r_*_arm is only set once a real
  // low has been seen, so a button held through reset release is ignored.
  // --------------------------------------------------------------------------
  logic [1:0] r_fill;
  logic [1:0] r_start_sync;
  logic [1:0] r_react_sync;
  logic       r_start_prev;
  logic       r_react_prev;
  logic       r_start_arm;
  logic       r_react_arm;
  logic       r_start_p;
  logic       r_react_p;
  logic       w_sync_valid;

  assign w_sync_valid = (r_fill == 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill       <= '0;
      r_start_sync <= '0;
      r_react_sync <= '0;
      r_start_prev <= 1'b0;
      r_react_prev <= 1'b0;
      r_start_arm  <= 1'b0;
      r_react_arm  <= 1'b0;
      r_start_p    <= 1'b0;
      r_react_p    <= 1'b0;
    end else begin
      if (!w_sync_valid) begin
        r_fill <= r_fill + 2'd1;
      end
      r_start_sync <= {r_start_sync[0], btn_start};
      r_react_sync <= {r_react_sync[0], btn_react};
      r_start_prev <= r_start_sync[1];
      r_react_prev <= r_react_sync[1];
      if (w_sync_valid && !r_start_sync[1]) begin
        r_start_arm <= 1'b1;
      end
      if (w_sync_valid && !r_react_sync[1]) begin
        r_react_arm <= 1'b1;
      end
      r_start_p <= r_start_arm & r_start_sync[1] & ~r_start_prev;
      r_react_p <= r_react_arm & r_react_sync[1] & ~r_react_prev;
    end
  end

  // --------------------------------------------------------------------------
  // 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, right-shifting
  // with the feedback entering at bit 15.
  // --------------------------------------------------------------------------
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Trial state machine
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_delay_w-1:0] r_wait_cnt;
  logic [c_delay_w-1:0] r_delay;
  logic [c_delay_w-1:0] w_new_delay;
  logic                 w_begin_trial;
  logic                 w_cnt_en;
  logic                 w_at_max;
  logic                 r_go;
  logic                 r_done;
  logic                 r_early;
  logic                 r_timeout;

  assign w_new_delay   = c_delay_w'(MIN_DELAY_MS) + c_delay_w'(r_lfsr[10:0]);
  assign w_begin_trial = r_start_p &
                         (r_state inside {ST_IDLE, ST_DONE, ST_EARLY, ST_TIMEOUT});
  // The tick that coincides with the react press is still counted.
  assign w_cnt_en      = (r_state == ST_ARMED) & ms_tick;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_EARLY, ST_TIMEOUT: begin
        if (r_start_p) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_react_p) begin
          w_state_nxt = ST_EARLY;
        end else if (r_wait_cnt == '0) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (r_react_p) begin
          w_state_nxt = ST_DONE;
        end else if (ms_tick && w_at_max) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_delay    <= '0;
      r_go       <= 1'b0;
      r_done     <= 1'b0;
      r_early    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_begin_trial) begin
        r_delay    <= w_new_delay;
        r_wait_cnt <= w_new_delay;
      end else if ((r_state == ST_WAIT) && ms_tick && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - c_delay_w'(1);
      end
      r_go      <= (w_state_nxt == ST_ARMED);
      r_done    <= (w_state_nxt == ST_DONE);
      r_early   <= (w_state_nxt == ST_EARLY);
      r_timeout <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  bcd_counter4 #(
    .MAX_BCD (c_max_bcd)
  ) u_bcd_counter4 (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_begin_trial),
    .en     (w_cnt_en),
    .q      (bcd),
    .at_max (w_at_max)
  );

  assign go_led   = r_go;
  assign done     = r_done;
  assign too_soon = r_early;
  assign timeout  = r_timeout;
  assign delay_ms = r_delay;

endmodule
`default_nettype wire

// File: tb/tb_reaction_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_fsm
// Description : Self-checking bench for reaction_fsm. A behavioural model
//               (integer counts, sample history, decimal display) predicts
//               every output each cycle; directed trials add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_fsm;

  localparam int MIN_MS = 1000;
  localparam int MAX_CT = 9999;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_ARMED = 2;
  localparam int P_DONE  = 3;
  localparam int P_EARLY = 4;
  localparam int P_TO    = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ms_tick = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic        go_led;
  logic [15:0] bcd;
  logic        done;
  logic        too_soon;
  logic        timeout;
  logic [11:0] delay_ms;

  int n_checks = 0;
  int n_fail   = 0;
  bit seen_go  = 1'b0;

  reaction_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .ms_tick   (ms_tick),
    .btn_start (btn_start),
    .btn_react (btn_react),
    .go_led    (go_led),
    .bcd       (bcd),
    .done      (done),
    .too_soon  (too_soon),
    .timeout   (timeout),
    .delay_ms  (delay_ms)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int          m_ph;
  int          m_edges;
  int          m_delay;
  int          m_wait;
  int          m_count;
  bit [3:0]    m_st_hist;
  bit [3:0]    m_rc_hist;
  bit [15:0]   m_lfsr;

  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // A press is seen three samples after the rise, and only if the rise
  // happens between two samples taken after reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph      <= P_IDLE;
      m_edges   <= 0;
      m_delay   <= 0;
      m_wait    <= 0;
      m_count   <= 0;
      m_st_hist <= '0;
      m_rc_hist <= '0;
      m_lfsr    <= 16'hACE1;
    end else begin
      bit sp;
      bit rp;
      sp = m_st_hist[2] && !m_st_hist[3] && (m_edges >= 4);
      rp = m_rc_hist[2] && !m_rc_hist[3] && (m_edges >= 4);
      m_edges   <= m_edges + 1;
      m_st_hist <= {m_st_hist[2:0], btn_start};
      m_rc_hist <= {m_rc_hist[2:0], btn_react};
      m_lfsr    <= lfsr_next(m_lfsr);
      case (m_ph)
        P_WAIT: begin
          if (rp) m_ph <= P_EARLY;
          else if (m_wait == 0) m_ph <= P_ARMED;
          else if (ms_tick) m_wait <= m_wait - 1;
        end
        P_ARMED: begin
          if (ms_tick && m_count < MAX_CT) m_count <= m_count + 1;
          if (rp) m_ph <= P_DONE;
          else if (ms_tick && m_count == MAX_CT) m_ph <= P_TO;
        end
        default: begin
          if (sp) begin
            m_ph    <= P_WAIT;
            m_delay <= MIN_MS + int'(m_lfsr[10:0]);
            m_wait  <= MIN_MS + int'(m_lfsr[10:0]);
            m_count <= 0;
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (rst) begin
      if (go_led === 1'b1) seen_go = 1'b1;
      check("go_led",   32'(go_led),   32'(m_ph == P_ARMED));
      check("done",     32'(done),     32'(m_ph == P_DONE));
      check("too_soon", 32'(too_soon), 32'(m_ph == P_EARLY));
      check("timeout",  32'(timeout),  32'(m_ph == P_TO));
      check("bcd",      32'(bcd),      32'(to_bcd(m_count)));
      check("delay_ms", 32'(delay_ms), 32'(m_delay));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ms_tick = 1'b1;
      step();
      ms_tick = 1'b0;
      step();
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    repeat (4) step();
    btn_start = 1'b0;
    repeat (6) step();
  endtask

  task automatic press_react();
    btn_react = 1'b1;
    repeat (4) step();
    btn_react = 1'b0;
    repeat (6) step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_go"},      32'(go_led),   32'd0);
    check({tag, "_done"},    32'(done),     32'd0);
    check({tag, "_soon"},    32'(too_soon), 32'd0);
    check({tag, "_timeout"}, 32'(timeout),  32'd0);
    check({tag, "_bcd"},     32'(bcd),      32'd0);
    check({tag, "_delay"},   32'(delay_ms), 32'd0);
  endtask

  int saved_delay;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    repeat (6) step();
    check_idle_outputs("idle");

    // Normal trial
    press_start();
    check("n_delay_range", 32'(delay_ms >= 12'd1000 && delay_ms <= 12'd3047), 32'd1);
    check("n_wait_go", 32'(go_led), 32'd0);
    ticks(m_delay);
    check("n_armed_go", 32'(go_led), 32'd1);
    ticks(237);
    check("n_bcd_pre", 32'(bcd), 32'h0237);
    press_react();
    check("n_done", 32'(done), 32'd1);
    check("n_bcd", 32'(bcd), 32'h0237);
    check("n_go_off", 32'(go_led), 32'd0);

    // Early press
    seen_go = 1'b0;
    press_start();
    ticks(5);
    press_react();
    check("e_too_soon", 32'(too_soon), 32'd1);
    check("e_bcd", 32'(bcd), 32'h0000);
    check("e_go_never", 32'(seen_go), 32'd0);

    // Timeout and saturation
    press_start();
    ticks(m_delay);
    ticks(10000);
    check("t_timeout", 32'(timeout), 32'd1);
    check("t_bcd", 32'(bcd), 32'h9999);
    ticks(50);
    check("t_bcd_hold", 32'(bcd), 32'h9999);
    check("t_timeout_hold", 32'(timeout), 32'd1);

    // React and tick in the same cycle
    press_start();
    ticks(m_delay);
    ticks(99);
    check("s_bcd_pre", 32'(bcd), 32'h0099);
    btn_react = 1'b1;
    repeat (3) step();
    ms_tick = 1'b1;
    step();
    ms_tick = 1'b0;
    btn_react = 1'b0;
    repeat (3) step();
    check("s_done", 32'(done), 32'd1);
    check("s_bcd", 32'(bcd), 32'h0100);

    // Restart from DONE; starts during WAIT are ignored
    press_start();
    check("r_done_off", 32'(done), 32'd0);
    check("r_bcd_clr", 32'(bcd), 32'h0000);
    check("r_delay_range", 32'(delay_ms >= 12'd1000 && delay_ms <= 12'd3047), 32'd1);
    saved_delay = m_delay;
    press_start();
    press_start();
    check("r_delay_kept", 32'(delay_ms), 32'(saved_delay));
    check("r_go_wait", 32'(go_led), 32'd0);

    // Reset in ARMED with buttons held through release
    ticks(m_wait);
    check("x_go", 32'(go_led), 32'd1);
    ticks(42);
    check("x_bcd_pre", 32'(bcd), 32'h0042);
    btn_react = 1'b1;
    btn_start = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("x_async");
    repeat (3) step();
    rst = 1'b1;
    repeat (12) step();
    check_idle_outputs("x_held");
    btn_react = 1'b0;
    btn_start = 1'b0;
    repeat (4) step();
    press_start();
    check("x_restart_range", 32'(delay_ms >= 12'd1000 && delay_ms <= 12'd3047), 32'd1);
    check("x_restart_go", 32'(go_led), 32'd0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reaction_fsm.md
REACTION_FSM -- requirements
Module: reaction_fsm

Interface
REQ-001 Parameter MIN_DELAY_MS, default 1000, minimum random wait in ms.
REQ-002 Parameter MAX_COUNT, default 9999, reaction count at which TIMEOUT is declared.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ms_tick  input  1  one-clk strobe every 1 ms, from the divider stage.
REQ-007 btn_start  input  1  debounced start button, asynchronous to clk.
REQ-008 btn_react  input  1  debounced reaction button, asynchronous to clk.
REQ-009 go_led  output  1  high only in ARMED.
REQ-010 bcd  output  16  four BCD digits of reaction ms, [15:12] thousands ... [3:0] units.
REQ-011 done  output  1  high in DONE.
REQ-012 too_soon  output  1  high in EARLY.
REQ-013 timeout  output  1  high in TIMEOUT.
REQ-014 delay_ms  output  12  wait length latched at start, for display and bench use.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a rising-edge detector producing a 1-clk pulse (start_p, react_p); the first pulse appears 3 clk edges after the input rises.
REQ-016 A 16-bit Fibonacci LFSR SHALL advance every clk; taps 16,14,13,11.
REQ-017 States SHALL be IDLE, WAIT, ARMED, DONE, EARLY and TIMEOUT.
REQ-018 IDLE->WAIT on start_p: latch delay_ms = MIN_DELAY_MS + lfsr[10:0] (range 1000..3047), load the wait counter, clear bcd.
REQ-019 WAIT: decrement the wait counter on each ms_tick; on reaching 0, go to ARMED on the next clk.
REQ-020 WAIT->EARLY on react_p; react_p takes priority over a same-cycle expiry.
REQ-021 ARMED: increment bcd on each ms_tick with decimal carry (0009->0010, 0999->1000).
REQ-022 ARMED->DONE on react_p; if ms_tick arrives in the same cycle, the increment is applied and bcd then freezes.
REQ-023 ARMED->TIMEOUT when bcd equals MAX_COUNT and ms_tick occurs; bcd SHALL hold MAX_COUNT and never wrap.
REQ-024 DONE, EARLY and TIMEOUT -> WAIT on start_p, which starts a new trial exactly as REQ-018 does; react_p is ignored in these states.
REQ-025 start_p SHALL be ignored in WAIT and ARMED.
REQ-026 In IDLE, react_p is ignored; a same-cycle start_p and react_p SHALL take the start.
REQ-027 All outputs SHALL be registered and decoded from the state register; no combinational path from input to output.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, bcd=0, delay_ms=0, wait counter=0, lfsr=LFSR_SEED, synchronizer and edge-detect flops=0, and go_led, done, too_soon and timeout all 0.
REQ-029 Reset asserted in any state SHALL abort the trial; after release, no button edge is recognized until its input is seen low then high.

Structure
REQ-030 A shared package SHALL hold the state enumeration, MIN_DELAY_MS, MAX_COUNT and LFSR_SEED defaults, and the BCD digit width.
REQ-031 Sub-module bcd_counter4 SHALL implement the 4-digit clear/enable/saturating BCD counter.
REQ-032 The 2-flop synchronizers, edge detectors, LFSR and FSM SHALL live in reaction_fsm.

Verification
REQ-033 Normal trial: pulse start, wait delay_ms ticks, go_led=1, issue 237 ticks, press react -> done=1, bcd=16'h0237, go_led=0.
REQ-034 Early press: start, press react after 5 ticks in WAIT -> too_soon=1, go_led never asserted, bcd=0.
REQ-035 Timeout: start, reach ARMED, issue 10000 ticks with no press -> timeout=1, bcd=16'h9999 held for 50 further ticks.
REQ-036 Simultaneous: in ARMED with bcd=0099, react_p and ms_tick in the same cycle -> done=1, bcd=16'h0100.
REQ-037 Reset mid-trial: drop rst during ARMED with bcd=0042 -> all outputs 0 immediately, state IDLE; holding btn_react high through reset release produces no action.
REQ-038 Restart: from DONE, pulse start -> WAIT with bcd=0 and a new delay_ms within 1000..3047; start pulses during WAIT leave delay_ms unchanged.
